// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard input buffer: drain FSM states,
// CPU register offsets and STATUS word bit positions.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        SETTLE = 2'd2
    } drain_state_t;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int STAT_NONEMPTY  = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_READY     = 2;
    localparam int STAT_COUNT_LSB = 8;

    localparam logic [7:0] NULL_CHAR = 8'h00;

endpackage

// File: rtl/kbd_sync_fifo.sv
// Generic DEPTH x 8 synchronous FIFO with a combinational head output.
// Push while full and pop while empty are ignored.
module kbd_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage has no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_input_buffer.sv
// Drains the PS/2 front end into a local FIFO and presents the buffered
// characters to the CPU as a DATA/STATUS register pair with a level irq.
module kbd_input_buffer
    import kbd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [7:0]  ascii,
    input  logic        fifo_ready,
    output logic        rdn,
    input  logic        cpu_rd,
    input  logic        cpu_addr,
    output logic [31:0] cpu_dout,
    output logic        irq
);

    drain_state_t state, next_state;
    logic [7:0]   cap_reg, cap_next;
    logic         rdn_reg, rdn_next;
    logic         irq_reg;

    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [7:0]   fifo_head;
    logic [AW:0]  fifo_count;
    logic [31:0]  status_word;

    kbd_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (fifo_push),
        .din   (cap_reg),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            cap_reg <= '0;
            rdn_reg <= 1'b1;
        end else begin
            state   <= next_state;
            cap_reg <= cap_next;
            rdn_reg <= rdn_next;
        end
    end

    // A full local FIFO holds the FSM in IDLE so the front end keeps the character.
    always_comb begin
        next_state = state;
        cap_next   = cap_reg;
        rdn_next   = rdn_reg;
        fifo_push  = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_ready && !fifo_full) begin
                    cap_next   = ascii;
                    rdn_next   = 1'b0;
                    next_state = POP;
                end
            end
            POP: begin
                fifo_push  = (cap_reg != NULL_CHAR);
                rdn_next   = 1'b1;
                next_state = SETTLE;
            end
            SETTLE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign fifo_pop = cpu_rd && (cpu_addr == ADDR_DATA) && !fifo_empty;

    always_comb begin
        status_word                                = '0;
        status_word[STAT_NONEMPTY]                 = !fifo_empty;
        status_word[STAT_FULL]                     = fifo_full;
        status_word[STAT_READY]                    = fifo_ready;
        status_word[STAT_COUNT_LSB +: AW+1]        = fifo_count;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cpu_dout <= '0;
            irq_reg  <= 1'b0;
        end else begin
            irq_reg <= (fifo_count != '0);
            if (cpu_rd) begin
                if (cpu_addr == ADDR_DATA) begin
                    cpu_dout <= fifo_empty ? 32'h0 : {24'h0, fifo_head};
                end else begin
                    cpu_dout <= status_word;
                end
            end
        end
    end

    assign rdn = rdn_reg;
    assign irq = irq_reg;

endmodule
